// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between fetch and decode.
// Holds {PC, instruction} pairs in a DEPTH-entry circular FIFO. Decode sees
// the head through a valid/ready handshake. A flush empties the queue in
// one cycle.
//
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   enq_valid/enq_ready     fetch-side handshake (enq_ready from count only)
//   enq_PC, enq_instruction fetched pair
//   deq_valid/deq_ready     decode-side handshake
//   deq_PC, deq_instruction head pair (0 / NOP when empty)
//   flush                   redirect: discard all entries
//   count                   current occupancy
//
// Optional macro: FETCH_QUEUE_BYPASS_EN adds a zero-latency enq->deq path
// when the queue is empty.
module fetch_queue #(
    parameter int unsigned ADDRESS_BITS = 16,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [ADDRESS_BITS-1:0]      enq_PC,
    input  logic [31:0]                  enq_instruction,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [ADDRESS_BITS-1:0]      deq_PC,
    output logic [31:0]                  deq_instruction,
    input  logic                         flush,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [ADDRESS_BITS-1:0] pc;
        logic [31:0]             instr;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               empty_c;
    logic               enq_fire_c;
    logic               deq_fire_c;
    logic               bypass_c;

    assign empty_c   = (count_q == '0);
    assign enq_ready = (count_q != CNT_W'(DEPTH));
    assign count     = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue hands the incoming pair straight to decode; gated by reset
    // so outputs stay at their empty values while reset is asserted.
    assign bypass_c = reset && empty_c && enq_valid && !flush;
`else
    assign bypass_c = 1'b0;
`endif

    // A bypassed entry that decode consumes immediately is never written.
    assign enq_fire_c = enq_valid && enq_ready && !(bypass_c && deq_ready);
    assign deq_fire_c = !empty_c && deq_ready;

    // Head presentation with empty-queue defaults.
    always_comb begin
        deq_valid       = 1'b0;
        deq_PC          = '0;
        deq_instruction = NOP;
        if (bypass_c) begin
            deq_valid       = 1'b1;
            deq_PC          = enq_PC;
            deq_instruction = enq_instruction;
        end else if (!empty_c) begin
            deq_valid       = 1'b1;
            deq_PC          = mem_q[rd_ptr_q].pc;
            deq_instruction = mem_q[rd_ptr_q].instr;
        end
    end

    // Pointer/occupancy next state; flush overrides any handshake.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq_fire_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (enq_fire_c && !deq_fire_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (!enq_fire_c && deq_fire_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (enq_fire_c && !flush) begin
            mem_q[wr_ptr_q] <= '{pc: enq_PC, instr: enq_instruction};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, ADDRESS_BITS=16).
module tb_fetch_queue;

    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clock;
    logic          reset;
    logic          enq_valid;
    logic          enq_ready;
    logic [AW-1:0] enq_PC;
    logic [31:0]   enq_instruction;
    logic          deq_valid;
    logic          deq_ready;
    logic [AW-1:0] deq_PC;
    logic [31:0]   deq_instruction;
    logic          flush;
    logic [2:0]    count;

    int checks;
    int failures;

    fetch_queue #(.ADDRESS_BITS(AW), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .enq_PC          (enq_PC),
        .enq_instruction (enq_instruction),
        .deq_valid       (deq_valid),
        .deq_ready       (deq_ready),
        .deq_PC          (deq_PC),
        .deq_instruction (deq_instruction),
        .flush           (flush),
        .count           (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] instr_of(input logic [AW-1:0] pc);
        return 32'hA500_0000 | 32'(pc);
    endfunction

    logic [31:0] fill_instr [4];

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b0;
        enq_valid       = 1'b1;
        enq_PC          = 16'h0000;
        enq_instruction = 32'h0010_0093;
        deq_ready       = 1'b0;
        flush           = 1'b0;
        fill_instr[0]   = 32'h0010_0093;
        fill_instr[1]   = 32'h0020_0113;
        fill_instr[2]   = 32'h0030_0193;
        fill_instr[3]   = 32'h0040_0213;

        // Reset held with enq_valid asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_deq_valid", 64'(deq_valid), 64'd0);
            check_eq("rst_deq_instr", 64'(deq_instruction), 64'(NOP));
            check_eq("rst_deq_pc", 64'(deq_PC), 64'd0);
            check_eq("rst_count", 64'(count), 64'd0);
            check_eq("rst_enq_ready", 64'(enq_ready), 64'd1);
        end
        enq_valid = 1'b0;
        reset     = 1'b1;
        tick();

        // Fill with deq_ready low.
        for (int i = 0; i < 4; i++) begin
            enq_valid       = 1'b1;
            enq_PC          = AW'(4 * i);
            enq_instruction = fill_instr[i];
            #1;
            check_eq("fill_enq_ready", 64'(enq_ready), 64'd1);
            tick();
        end
        check_eq("full_count", 64'(count), 64'd4);
        check_eq("full_enq_ready", 64'(enq_ready), 64'd0);
        enq_PC          = 16'h0010;
        enq_instruction = 32'h0050_0293;
        tick();
        check_eq("full_reject_count", 64'(count), 64'd4);
        check_eq("full_head_pc", 64'(deq_PC), 64'h0000);

        // Drain in order.
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("drain_valid", 64'(deq_valid), 64'd1);
            check_eq("drain_pc", 64'(deq_PC), 64'(4 * i));
            check_eq("drain_instr", 64'(deq_instruction), 64'(fill_instr[i]));
            tick();
            if (i == 0) check_eq("drain_enq_ready", 64'(enq_ready), 64'd1);
        end
        check_eq("drained_valid", 64'(deq_valid), 64'd0);
        check_eq("drained_count", 64'(count), 64'd0);
        check_eq("drained_instr", 64'(deq_instruction), 64'(NOP));

        // Preload two entries, then simultaneous enq/deq for 10 cycles.
        deq_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            enq_valid       = 1'b1;
            enq_PC          = AW'(16'h0100 + 4 * i);
            enq_instruction = instr_of(enq_PC);
            tick();
        end
        check_eq("sim_pre_count", 64'(count), 64'd2);
        deq_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            enq_PC          = AW'(16'h0108 + 4 * k);
            enq_instruction = instr_of(enq_PC);
            #1;
            check_eq("sim_deq_pc", 64'(deq_PC), 64'(16'h0100 + 4 * k));
            check_eq("sim_deq_instr", 64'(deq_instruction), 64'(instr_of(AW'(16'h0100 + 4 * k))));
            tick();
            check_eq("sim_count", 64'(count), 64'd2);
        end

        // Grow to three entries, then flush with both handshakes active.
        deq_ready       = 1'b0;
        enq_PC          = 16'h0130;
        enq_instruction = instr_of(enq_PC);
        tick();
        check_eq("pre_flush_count", 64'(count), 64'd3);
        flush           = 1'b1;
        deq_ready       = 1'b1;
        enq_PC          = 16'h0200;
        enq_instruction = instr_of(enq_PC);
        tick();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_deq_valid", 64'(deq_valid), 64'd0);
        check_eq("flush_enq_ready", 64'(enq_ready), 64'd1);
        enq_valid       = 1'b1;
        enq_PC          = 16'h0300;
        enq_instruction = instr_of(enq_PC);
        tick();
        enq_valid = 1'b0;
        #1;
        check_eq("post_flush_count", 64'(count), 64'd1);
        check_eq("post_flush_pc", 64'(deq_PC), 64'h0300);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        check_eq("post_flush_empty", 64'(count), 64'd0);

        // Async reset between edges with two entries held.
        for (int i = 0; i < 2; i++) begin
            enq_valid       = 1'b1;
            enq_PC          = AW'(16'h0030 + 4 * i);
            enq_instruction = instr_of(enq_PC);
            tick();
        end
        enq_valid = 1'b0;
        check_eq("arst_pre_count", 64'(count), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_deq_valid", 64'(deq_valid), 64'd0);
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_deq_instr", 64'(deq_instruction), 64'(NOP));
        tick();
        reset = 1'b1;
        tick();
        enq_valid       = 1'b1;
        enq_PC          = 16'h0040;
        enq_instruction = instr_of(enq_PC);
        tick();
        enq_valid = 1'b0;
        #1;
        check_eq("arst_first_valid", 64'(deq_valid), 64'd1);
        check_eq("arst_first_pc", 64'(deq_PC), 64'h0040);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        check_eq("arst_drained", 64'(count), 64'd0);

        // Empty queue with enq and deq both asserted.
        enq_valid       = 1'b1;
        deq_ready       = 1'b1;
        enq_PC          = 16'h0020;
        enq_instruction = instr_of(enq_PC);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check_eq("byp_valid", 64'(deq_valid), 64'd1);
        check_eq("byp_pc", 64'(deq_PC), 64'h0020);
        tick();
        enq_valid = 1'b0;
        #1;
        check_eq("byp_count", 64'(count), 64'd0);
        check_eq("byp_after_valid", 64'(deq_valid), 64'd0);
`else
        check_eq("lat_same_valid", 64'(deq_valid), 64'd0);
        tick();
        enq_valid = 1'b0;
        #1;
        check_eq("lat_next_valid", 64'(deq_valid), 64'd1);
        check_eq("lat_next_pc", 64'(deq_PC), 64'h0020);
        check_eq("lat_next_count", 64'(count), 64'd1);
        tick();
        check_eq("lat_drained", 64'(count), 64'd0);
`endif
        deq_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
